// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for the ALU command issuer: op codes, the legal-op
// check and the issue FSM state encoding.
package alu_cmd_issuer_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_SRL = 3'b100;
    localparam logic [OP_W-1:0] OP_SRA = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Returns 1 for the six ALU op codes and 0 for every other code.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SRL, OP_SRA: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; push is ignored when full
// and pop is ignored when empty. Read data is the current head entry.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage.
    // NOTE: storage is not reset; occupancy decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: buffers requests, drives one command at a time to an
// external combinational ALU, and returns the registered result with its tag.
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [OP_W-1:0]        req_op,
    input  logic [DATA_W-1:0]      req_a,
    input  logic [DATA_W-1:0]      req_b,
    input  logic [TAG_W-1:0]       req_tag,
    output logic [DATA_W-1:0]      alu_A,
    output logic [DATA_W-1:0]      alu_B,
    output logic [OP_W-1:0]        alu_op,
    input  logic [DATA_W-1:0]      alu_C,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] fifo_count
);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    cmd_t  push_cmd;
    cmd_t  head_cmd;
    logic  fifo_full;
    logic  fifo_empty;
    logic  fifo_pop;
    logic  load;

    state_e            state_q,     state_d;
    logic [OP_W-1:0]   op_q,        op_d;
    logic [DATA_W-1:0] a_q,         a_d;
    logic [DATA_W-1:0] b_q,         b_d;
    logic [TAG_W-1:0]  tag_q,       tag_d;
    logic              err_q,       err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic [TAG_W-1:0]  rsp_tag_q,   rsp_tag_d;
    logic              rsp_err_q,   rsp_err_d;

    assign push_cmd = '{op: req_op, a: req_a, b: req_b, tag: req_tag};

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid && req_ready),
        .wdata (push_cmd),
        .pop   (fifo_pop),
        .rdata (head_cmd),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req_ready = !fifo_full;

    // Next-state logic: issue sequencing, operand loading and result capture.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        tag_d       = tag_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        load        = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The ALU has had a full cycle on stable operands; capture now.
                rsp_valid_d = 1'b1;
                rsp_data_d  = err_q ? '0 : alu_C;
                rsp_tag_d   = tag_q;
                rsp_err_d   = err_q;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        load    = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Illegal ops still occupy an issue slot but present a harmless ADD to the ALU.
        if (load) begin
            fifo_pop = 1'b1;
            op_d     = is_legal_op(head_cmd.op) ? head_cmd.op : OP_ADD;
            a_d      = head_cmd.a;
            b_d      = head_cmd.b;
            tag_d    = head_cmd.tag;
            err_d    = !is_legal_op(head_cmd.op);
        end
    end

    // State, operand and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tag_q       <= tag_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_A     = a_q;
    assign alu_B     = b_q;
    assign alu_op    = op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural ALU attached and
// an in-order scoreboard of expected responses.
module tb_alu_cmd_issuer;
    import alu_cmd_issuer_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [31:0]       req_a;
    logic [31:0]       req_b;
    logic [TAG_W-1:0]  req_tag;
    logic [31:0]       alu_A;
    logic [31:0]       alu_B;
    logic [2:0]        alu_op;
    logic [31:0]       alu_C;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;
    logic [CW-1:0]     fifo_count;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t sb_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   prev_cyc   = 0;
    bit   have_prev  = 0;
    bit   gap_en     = 0;

    alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_op     (alu_op),
        .alu_C      (alu_C),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .fifo_count (fifo_count)
    );

    // External combinational ALU.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_C = alu_A + alu_B;
            OP_SUB:  alu_C = alu_A - alu_B;
            OP_AND:  alu_C = alu_A & alu_B;
            OP_OR:   alu_C = alu_A | alu_B;
            OP_SRL:  alu_C = (alu_B >= 32) ? 32'h0 : (alu_A >> alu_B[4:0]);
            OP_SRA:  alu_C = (alu_B >= 32) ? {32{alu_A[31]}}
                                           : 32'($signed(alu_A) >>> alu_B[4:0]);
            default: alu_C = 32'h0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: compare every response handshake against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_tag",  rsp_tag,  e.tag);
                check("rsp_err",  rsp_err,  e.err);
                if (gap_en) begin
                    if (have_prev) check("rsp_gap", cyc - prev_cyc, 2);
                    have_prev = 1;
                    prev_cyc  = cyc;
                end
            end
        end
    end

    // Offer one request; returns 1 ns after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp_data,
                        input logic exp_err);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("req_accept_timeout", 0, 1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb_q.push_back('{data: exp_data, tag: tag, err: exp_err});
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || rsp_valid || fifo_count != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", (n < 200), 1);
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rsp_valid_timeout", rsp_valid, 1);
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        // Driving req_valid during reset must have no effect.
        req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  req_ready,  1);
        check("rst_rsp_valid",  rsp_valid,  0);
        check("rst_fifo_count", fifo_count, 0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        check("rst_alu_A",    alu_A,    0);
        check("rst_alu_op",   alu_op,   0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_tag",  rsp_tag,  0);
        check("rst_rsp_err",  rsp_err,  0);
        check("rst_fifo_count_post", fifo_count, 0);

        // ADD with latency: valid must appear two edges after acceptance.
        rsp_ready = 1'b1;
        send(OP_ADD, 32'd5, 32'd3, 4'd1, 32'd8, 1'b0);
        check("lat_e0_valid", rsp_valid, 0);
        @(posedge clk); #1;
        check("lat_e1_valid", rsp_valid, 0);
        check("issue_alu_A",  alu_A,  32'd5);
        check("issue_alu_B",  alu_B,  32'd3);
        check("issue_alu_op", alu_op, OP_ADD);
        @(posedge clk); #1;
        check("lat_e2_valid", rsp_valid, 1);
        drain();

        // SUB, SRA, SRL with out-of-range shift.
        send(OP_SUB, 32'd3, 32'd5, 4'd2, 32'hFFFF_FFFE, 1'b0);
        send(OP_SRA, 32'h8000_0000, 32'd4, 4'd3, 32'hF800_0000, 1'b0);
        send(OP_SRL, 32'h8000_0000, 32'd32, 4'd4, 32'h0000_0000, 1'b0);
        send(OP_SRA, 32'h8000_0000, 32'd40, 4'd5, 32'hFFFF_FFFF, 1'b0);
        drain();

        // Backpressure: five accepted, then full.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(OP_ADD, 32'(i), 32'd100, TAG_W'(i), 32'(i + 100), 1'b0);
        req_valid = 1'b1;
        req_op    = OP_ADD;
        req_tag   = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_req_ready",  req_ready,  0);
            check("full_fifo_count", fifo_count, 4);
            check("hold_rsp_valid",  rsp_valid,  1);
            check("hold_rsp_tag",    rsp_tag,    0);
            check("hold_rsp_data",   rsp_data,   32'd100);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        have_prev = 0;
        gap_en    = 1;
        rsp_ready = 1'b1;
        drain();
        gap_en = 0;

        // Illegal op after an AND so the forced ADD code is observable.
        send(OP_AND, 32'hFF, 32'h0F, 4'd2, 32'h0F, 1'b0);
        drain();
        send(3'b110, 32'd7, 32'd9, 4'd3, 32'd0, 1'b1);
        @(posedge clk); #1;
        check("illegal_alu_op", alu_op, OP_ADD);
        check("illegal_alu_A",  alu_A,  32'd7);
        drain();
        send(3'b111, 32'd1, 32'd1, 4'd6, 32'd0, 1'b1);
        send(OP_OR, 32'hF0, 32'h0F, 4'd4, 32'hFF, 1'b0);
        drain();

        // Simultaneous push and pop with two entries queued.
        rsp_ready = 1'b0;
        send(OP_ADD, 32'd10, 32'd1, 4'd7, 32'd11, 1'b0);
        send(OP_ADD, 32'd20, 32'd1, 4'd8, 32'd21, 1'b0);
        send(OP_ADD, 32'd30, 32'd1, 4'd9, 32'd31, 1'b0);
        wait_rsp_valid();
        check("pp_count_before", fifo_count, 2);
        rsp_ready = 1'b1;
        send(OP_ADD, 32'd40, 32'd1, 4'd10, 32'd41, 1'b0);
        check("pp_count_after", fifo_count, 2);
        drain();
        repeat (4) @(posedge clk);
        #1 check("pp_no_extra", rsp_valid, 0);

        // Reset asserted mid-HOLD.
        rsp_ready = 1'b0;
        send(OP_ADD, 32'd10, 32'd20, 4'd11, 32'd30, 1'b0);
        send(OP_SUB, 32'd10, 32'd20, 4'd12, 32'hFFFF_FFF6, 1'b0);
        wait_rsp_valid();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid",  rsp_valid,  0);
        check("mid_rst_fifo_count", fifo_count, 0);
        check("mid_rst_alu_A",      alu_A,      0);
        check("mid_rst_alu_B",      alu_B,      0);
        check("mid_rst_alu_op",     alu_op,     0);
        check("mid_rst_req_ready",  req_ready,  1);
        sb_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1 check("post_rst_req_ready", req_ready, 1);
        rsp_ready = 1'b1;
        send(OP_ADD, 32'd1, 32'd1, 4'd13, 32'd2, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
